// File: rtl/ca_row_sequencer.sv
// Row sequencer for a 1-D cellular automaton display: seeds, runs and re-seeds rows per frame,
// adopts new rules only during vertical blanking. Optional macro CA_LFSR_SEED_EN seeds from an LFSR.
module ca_row_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SEED_POS = 320,
  parameter logic [7:0] RULE_RESET = 8'd90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       evolve,
  input  logic       restart,
  input  logic       rule_req,
  input  logic [7:0] rule_in,
  output logic       rule_ack,
  output logic [7:0] rule,
  output logic       shift_en,
  output logic       inject,
  output logic       seed_bit,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_END    = 10'(V_ACTIVE);
  localparam logic [9:0] SEED_COL = 10'(SEED_POS);

  typedef enum logic [1:0] {IDLE, VBLANK, SEED, RUN} state_t;

  state_t state, state_nxt;
  logic   restart_pending;
  logic   adopted;
  logic   adopt;
  logic   frame_start, frame_end;
  logic   active, seeding;

  assign frame_start = (vpos == 10'd0) && (hpos == 10'd0);
  assign frame_end   = (vpos == V_END) && (hpos == 10'd0);
  assign adopt       = (state == VBLANK) && rule_req && !adopted;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_end) state_nxt = VBLANK;
      VBLANK:  if (frame_start) state_nxt = (restart_pending || !evolve) ? SEED : RUN;
      SEED:    if (display_on && hpos == H_LAST) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = VBLANK;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CA_LFSR_SEED_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset)       lfsr <= 16'hACE1;
    else if (inject) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
`endif

  // The frame's first pixel arrives on the same cycle VBLANK is left, so it is
  // attributed to the incoming state to give full-width rows.
  always_comb begin
    active   = 1'b0;
    seeding  = 1'b0;
    shift_en = 1'b0;
    inject   = 1'b0;
    seed_bit = 1'b0;
    case (state)
      SEED:    begin active = 1'b1; seeding = 1'b1; end
      RUN:     active = 1'b1;
      VBLANK:  begin
        active  = (state_nxt != VBLANK);
        seeding = (state_nxt == SEED);
      end
      default: ;
    endcase
    shift_en = display_on && active;
    inject   = display_on && seeding;
`ifdef CA_LFSR_SEED_EN
    seed_bit = inject && lfsr[0];
`else
    seed_bit = inject && (hpos == SEED_COL);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rule            <= RULE_RESET;
      rule_ack        <= 1'b0;
      adopted         <= 1'b0;
      restart_pending <= 1'b1;
      frame_cnt       <= 8'd0;
    end else begin
      rule_ack <= adopt;
      if (adopt) rule <= rule_in;
      // One adoption per blanking interval; cleared once VBLANK is left.
      adopted <= (state == VBLANK) ? (adopted || adopt) : 1'b0;
      if (restart)
        restart_pending <= 1'b1;
      else if (state_nxt == SEED && state != SEED)
        restart_pending <= 1'b0;
      if (state == RUN && state_nxt == VBLANK)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ca_row_sequencer.md
CA_ROW_SEQUENCER -- requirements
Module: ca_row_sequencer

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter SEED_POS, default 320, column of the single seed cell.
REQ-004 Parameter RULE_RESET, default 90, rule value loaded at reset.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 display_on  input  1  visible-area flag from the sync generator.
REQ-008 hpos  input  10  current pixel column.
REQ-009 vpos  input  10  current line.
REQ-010 evolve  input  1  1 = next frame continues from last row, 0 = reseed every frame.
REQ-011 restart  input  1  single-cycle pulse requesting a reseed at the next frame.
REQ-012 rule_req  input  1  request to adopt rule_in, held high until rule_ack.
REQ-013 rule_in  input  8  candidate Wolfram rule, stable while rule_req is high.
REQ-014 rule_ack  output  1  one-cycle pulse: rule_in adopted.
REQ-015 rule  output  8  registered active rule driven to the CA datapath.
REQ-016 shift_en  output  1  CA shift-register advance enable, combinational.
REQ-017 inject  output  1  select seed_bit instead of the computed cell, combinational.
REQ-018 seed_bit  output  1  seed row cell value, combinational.
REQ-019 frame_cnt  output  8  completed-frame counter.

Function
REQ-020 FSM states: IDLE, VBLANK, SEED, RUN, held in a registered state variable.
REQ-021 IDLE -> VBLANK on the cycle with vpos==V_ACTIVE and hpos==0; no other exit.
REQ-022 VBLANK -> SEED on the cycle with vpos==0, hpos==0 if restart_pending or evolve==0, else VBLANK -> RUN.
REQ-023 SEED -> RUN on the cycle with display_on==1 and hpos==H_ACTIVE-1, so exactly one seeded row.
REQ-024 RUN -> VBLANK on the cycle with vpos==V_ACTIVE and hpos==0; frame_cnt increments on the same edge, wrapping 255 -> 0.
REQ-025 shift_en = display_on AND (state is SEED or RUN); 0 in IDLE and VBLANK.
REQ-026 inject = shift_en AND state==SEED.
REQ-027 seed_bit = (hpos==SEED_POS) when inject is 1, else 0 (see REQ-037).
REQ-028 restart sets a sticky restart_pending flag, cleared on the edge that enters SEED; a restart arriving on that same edge stays pending.
REQ-029 Rule adoption only in VBLANK: first VBLANK cycle with rule_req==1 loads rule <= rule_in and pulses rule_ack for one cycle.
REQ-030 At most one adoption per VBLANK interval; rule_req high outside VBLANK is held off (rule_ack 0) until the next VBLANK.
REQ-031 Requester drops rule_req the cycle after rule_ack; rule_req still high at a later VBLANK is a new request.
REQ-032 rule never changes while state is SEED or RUN (tear-free).

Reset
REQ-033 On reset: state=IDLE, rule=RULE_RESET, frame_cnt=0, rule_ack=0, restart_pending=1.
REQ-034 Reset mid-frame: shift_en and inject deassert from the next cycle; the first post-reset frame is always seeded.
REQ-035 Combinational outputs shift_en, inject, seed_bit read 0 while state is IDLE.

Configuration
REQ-036 Macro CA_LFSR_SEED_EN selects the seed source.
REQ-037 Defined: seed_bit = lfsr[0] when inject is 1; 16-bit Fibonacci LFSR, taps 16,14,13,11, reset value 16'hACE1, advances only on cycles with inject==1, never reloaded between frames.
REQ-038 Undefined: no LFSR in the netlist; seed_bit per REQ-027.

Verification
REQ-039 Reset, run 2 frames, evolve=0 -> frame 1 row 0: inject=1 for 640 cycles, seed_bit=1 only at hpos=320; shift_en=1 for 480x640 cycles per frame.
REQ-040 evolve=1 after first seeded frame -> next frame enters RUN directly, inject never 1; restart pulse mid-frame -> following frame seeded once, then RUN.
REQ-041 rule_req=1, rule_in=8'd30 asserted at vpos=100 -> rule stays 90 until vpos=480,hpos=0 VBLANK cycle; then rule=30, rule_ack single pulse.
REQ-042 rule_req held high for 2 frames -> exactly one rule_ack per VBLANK, none during active video.
REQ-043 Run 256 frames -> frame_cnt returns 0; reset asserted at vpos=200 -> shift_en 0 next cycle, state IDLE, rule=90.
REQ-044 CA_LFSR_SEED_EN defined -> seeded row seed_bit sequence equals reference LFSR from 16'hACE1 for 640 steps; second seeded frame continues the sequence.
